// File: rtl/gf180mcu_osu_sc_lshifup_pkg.sv
// Shared types and sizing helpers for the low-to-high voltage-domain crossing bank.
// The optional deglitch filter in the top level is enabled by LSHIFUP_DEGLITCH_EN.
package gf180mcu_osu_sc_lshifup_pkg;

   typedef enum logic [1:0] {
      ISO    = 2'd0,
      SETTLE = 2'd1,
      ACTIVE = 2'd2
   } lshifup_state_e;

   // Wide enough to hold SETTLE_CYCLES itself so the counter can saturate there.
   function automatic int cnt_width(input int settle_cycles);
      return (settle_cycles < 1) ? 1 : $clog2(settle_cycles + 1);
   endfunction

endpackage

// File: rtl/gf180mcu_osu_sc_lshifup_sync.sv
// Multi-bit flop-chain synchroniser into the high-voltage clock domain.
// Every bit gets its own STAGES-deep chain; all flops clear on asynchronous reset.
module gf180mcu_osu_sc_lshifup_sync #(
   parameter int W      = 1,
   parameter int STAGES = 2
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] chain_p [STAGES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < STAGES; i++) chain_p[i] <= '0;
      end else begin
         chain_p[0] <= d;
         for (int i = 1; i < STAGES; i++) chain_p[i] <= chain_p[i-1];
      end
   end

   assign q = chain_p[STAGES-1];

endmodule

// File: rtl/gf180mcu_osu_sc_lshifup_sync_bank.sv
// N-channel level-up crossing bank: synchronisers, isolation clamp and power-up settle FSM.
// Define LSHIFUP_DEGLITCH_EN to add a two-sample agreement filter on each data channel.
module gf180mcu_osu_sc_lshifup_sync_bank #(
   parameter int               WIDTH         = 8,
   parameter int               SYNC_STAGES   = 2,
   parameter int               SETTLE_CYCLES = 16,
   parameter logic [WIDTH-1:0] CLAMP_VAL     = '0
) (
   input  logic             CLK,
   input  logic             RN,
   input  logic [WIDTH-1:0] A,
   input  logic             PWR_OK,
   input  logic             EN,
   input  logic             CLR_FLAG,
   output logic [WIDTH-1:0] Y,
   output logic             READY,
   output logic             DROP_FLAG
);
   import gf180mcu_osu_sc_lshifup_pkg::*;

   localparam int              CNT_W    = cnt_width(SETTLE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE_CYCLES);

   logic [WIDTH-1:0] a_s;
   logic             pwr_s;
   lshifup_state_e   state, state_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             drop_set;
   logic [WIDTH-1:0] data_out;

   gf180mcu_osu_sc_lshifup_sync #(.W(WIDTH), .STAGES(SYNC_STAGES)) u_sync_a (
      .clk   (CLK),
      .rst_n (RN),
      .d     (A),
      .q     (a_s)
   );

   gf180mcu_osu_sc_lshifup_sync #(.W(1), .STAGES(SYNC_STAGES)) u_sync_pwr (
      .clk   (CLK),
      .rst_n (RN),
      .d     (PWR_OK),
      .q     (pwr_s)
   );

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         ISO: begin
            cnt_nxt = '0;
            if (pwr_s && EN) state_nxt = SETTLE;
         end
         SETTLE: begin
            if (!pwr_s || !EN) begin
               state_nxt = ISO;
               cnt_nxt   = '0;
            end else begin
               if (cnt != CNT_MAX) cnt_nxt = cnt + CNT_W'(1);
               if (cnt == CNT_LAST) state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (!pwr_s || !EN) state_nxt = ISO;
         end
         default: begin
            state_nxt = ISO;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Only a supply loss while live counts as a drop; a software disable does not.
   assign drop_set = (state == ACTIVE) && !pwr_s;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         state     <= ISO;
         cnt       <= '0;
         DROP_FLAG <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (drop_set)      DROP_FLAG <= 1'b1;
         else if (CLR_FLAG) DROP_FLAG <= 1'b0;
      end
   end

`ifdef LSHIFUP_DEGLITCH_EN
   logic [WIDTH-1:0] a_dly_p1;
   logic [WIDTH-1:0] y_filt_p2;

   always_ff @(posedge CLK or negedge RN) begin
      if (!RN) begin
         a_dly_p1  <= CLAMP_VAL;
         y_filt_p2 <= CLAMP_VAL;
      end else begin
         a_dly_p1 <= a_s;
         for (int i = 0; i < WIDTH; i++)
            if (a_s[i] == a_dly_p1[i]) y_filt_p2[i] <= a_s[i];
      end
   end

   assign data_out = y_filt_p2;
`else
   assign data_out = a_s;
`endif

   // Output decodes from the state register, so the clamp lands on the same edge as ISO entry.
   assign Y     = (state == ACTIVE) ? data_out : CLAMP_VAL;
   assign READY = (state == ACTIVE);

endmodule

// File: tb/tb_gf180mcu_osu_sc_lshifup_sync_bank.sv
// Directed self-checking bench for the crossing bank (default parameters).
// Data latency expectations follow LSHIFUP_DEGLITCH_EN when it is defined.
module tb_gf180mcu_osu_sc_lshifup_sync_bank;

`ifdef LSHIFUP_DEGLITCH_EN
   localparam int  LAT      = 4;
   localparam bit  DEGLITCH = 1'b1;
`else
   localparam int  LAT      = 2;
   localparam bit  DEGLITCH = 1'b0;
`endif
   localparam int  PWRUP    = 19;

   logic       CLK;
   logic       RN;
   logic [7:0] A;
   logic       PWR_OK;
   logic       EN;
   logic       CLR_FLAG;
   logic [7:0] Y;
   logic       READY;
   logic       DROP_FLAG;

   int checks = 0;
   int errors = 0;

   gf180mcu_osu_sc_lshifup_sync_bank dut (
      .CLK       (CLK),
      .RN        (RN),
      .A         (A),
      .PWR_OK    (PWR_OK),
      .EN        (EN),
      .CLR_FLAG  (CLR_FLAG),
      .Y         (Y),
      .READY     (READY),
      .DROP_FLAG (DROP_FLAG)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic test_reset();
      RN = 1'b0; A = 8'hA5; PWR_OK = 1'b0; EN = 1'b0; CLR_FLAG = 1'b0;
      tick(); tick();
      checks++;
      if (Y !== 8'h00) begin errors++; $display("FAIL reset_y got %h exp 00", Y); end
      checks++;
      if (READY !== 1'b0) begin errors++; $display("FAIL reset_ready got %b exp 0", READY); end
      checks++;
      if (DROP_FLAG !== 1'b0) begin errors++; $display("FAIL reset_drop got %b exp 0", DROP_FLAG); end
      RN = 1'b1;
      tick();
   endtask

   task automatic test_power_up();
      PWR_OK = 1'b1; EN = 1'b1; A = 8'hA5;
      for (int k = 1; k <= PWRUP; k++) begin
         tick();
         checks++;
         if (READY !== (k == PWRUP)) begin
            errors++; $display("FAIL pwrup_ready cycle %0d got %b exp %b", k, READY, (k == PWRUP));
         end
         if (k < PWRUP) begin
            checks++;
            if (Y !== 8'h00) begin errors++; $display("FAIL pwrup_clamp cycle %0d got %h exp 00", k, Y); end
         end
      end
      checks++;
      if (Y !== 8'hA5) begin errors++; $display("FAIL pwrup_y got %h exp a5", Y); end
   endtask

   task automatic test_data_latency();
      A = 8'h3C;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (Y !== 8'h3C) begin errors++; $display("FAIL data_pre got %h exp 3c", Y); end
      A = 8'hC3;
      for (int k = 1; k <= LAT; k++) begin
         tick();
         checks++;
         if (Y !== ((k == LAT) ? 8'hC3 : 8'h3C)) begin
            errors++; $display("FAIL data_lat cycle %0d got %h exp %h", k, Y, (k == LAT) ? 8'hC3 : 8'h3C);
         end
      end
   endtask

   task automatic test_supply_drop();
      PWR_OK = 1'b0;
      tick(); tick();
      checks++;
      if (READY !== 1'b1 || Y !== 8'hC3) begin
         errors++; $display("FAIL drop_early got ready=%b y=%h exp ready=1 y=c3", READY, Y);
      end
      tick();
      checks++;
      if (READY !== 1'b0 || Y !== 8'h00) begin
         errors++; $display("FAIL drop_clamp got ready=%b y=%h exp ready=0 y=00", READY, Y);
      end
      checks++;
      if (DROP_FLAG !== 1'b1) begin errors++; $display("FAIL drop_flag got %b exp 1", DROP_FLAG); end
      tick(); tick();
      checks++;
      if (DROP_FLAG !== 1'b1) begin errors++; $display("FAIL drop_sticky got %b exp 1", DROP_FLAG); end
      CLR_FLAG = 1'b1;
      tick();
      CLR_FLAG = 1'b0;
      checks++;
      if (DROP_FLAG !== 1'b0) begin errors++; $display("FAIL drop_clear got %b exp 0", DROP_FLAG); end
   endtask

   task automatic test_settle_abort();
      PWR_OK = 1'b1;
      // pwr_s rises at cycle 2, SETTLE entered at 3, count reaches 10 at 13
      for (int k = 0; k < 13; k++) tick();
      checks++;
      if (READY !== 1'b0) begin errors++; $display("FAIL abort_pre got %b exp 0", READY); end
      EN = 1'b0;
      tick();
      EN = 1'b1;
      for (int k = 1; k <= 17; k++) begin
         tick();
         checks++;
         if (READY !== (k == 17)) begin
            errors++; $display("FAIL abort_ready cycle %0d got %b exp %b", k, READY, (k == 17));
         end
      end
      checks++;
      if (Y !== 8'hC3 || DROP_FLAG !== 1'b0) begin
         errors++; $display("FAIL abort_post got y=%h drop=%b exp y=c3 drop=0", Y, DROP_FLAG);
      end
   endtask

   task automatic test_set_clear_same_cycle();
      PWR_OK = 1'b0;
      tick(); tick();
      CLR_FLAG = 1'b1;
      tick();
      CLR_FLAG = 1'b0;
      checks++;
      if (DROP_FLAG !== 1'b1) begin errors++; $display("FAIL setclr_win got %b exp 1", DROP_FLAG); end
      tick();
      checks++;
      if (DROP_FLAG !== 1'b1) begin errors++; $display("FAIL setclr_hold got %b exp 1", DROP_FLAG); end
   endtask

   task automatic test_async_reset();
      PWR_OK = 1'b1;
      for (int k = 0; k < PWRUP; k++) tick();
      A = 8'hFF;
      for (int k = 0; k <= LAT; k++) tick();
      checks++;
      if (READY !== 1'b1 || Y !== 8'hFF || DROP_FLAG !== 1'b1) begin
         errors++; $display("FAIL arst_pre got ready=%b y=%h drop=%b exp 1 ff 1", READY, Y, DROP_FLAG);
      end
      #2 RN = 1'b0;
      #1;
      checks++;
      if (Y !== 8'h00 || READY !== 1'b0 || DROP_FLAG !== 1'b0) begin
         errors++; $display("FAIL arst_now got ready=%b y=%h drop=%b exp 0 00 0", READY, Y, DROP_FLAG);
      end
      tick();
      RN = 1'b1;
      for (int k = 1; k <= PWRUP; k++) begin
         tick();
         checks++;
         if (READY !== (k == PWRUP)) begin
            errors++; $display("FAIL arst_resettle cycle %0d got %b exp %b", k, READY, (k == PWRUP));
         end
      end
      checks++;
      if (Y !== 8'hFF) begin errors++; $display("FAIL arst_y got %h exp ff", Y); end
   endtask

   task automatic test_pulse_filter();
      logic [7:0] exp_y;
      A = 8'h00;
      for (int k = 0; k < 6; k++) tick();
      checks++;
      if (Y !== 8'h00) begin errors++; $display("FAIL pulse_pre got %h exp 00", Y); end
      A = 8'hFF;
      for (int k = 1; k <= 6; k++) begin
         tick();
         if (k == 1) A = 8'h00;
         exp_y = (!DEGLITCH && k == 2) ? 8'hFF : 8'h00;
         checks++;
         if (Y !== exp_y) begin errors++; $display("FAIL pulse cycle %0d got %h exp %h", k, Y, exp_y); end
      end
   endtask

   initial begin
      test_reset();
      test_power_up();
      test_data_latency();
      test_supply_drop();
      test_settle_abort();
      test_set_clear_same_cycle();
      test_async_reset();
      test_pulse_filter();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
